cmp_share_arbiter: RTL and testbench

- Shares one WIDTH-bit inequality comparator (s = OR of bitwise XOR of a and b) between two requesters through a 4-phase req/done handshake.
- The comparator datapath sits inside this block: operands are latched from the granted requester, the result is registered and returned with done.
- Sits between the comparison datapath and the two client units that need equality checks.

---
 rtl/cmp_share_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter
//   Two requesters share a single WIDTH-bit inequality comparator
//   (result = |(a ^ b)) through a 4-phase req/done handshake.
//
//   Handshake (each requester n = 0/1):
//     The requester raises reqN with aN/bN stable and holds req high until it
//     sees doneN high. doneN then stays high until reqN is sampled low.
//     resN is valid while doneN is high and otherwise holds its last value.
//
//   Optional build macro: CMP_ARB_RR_EN
//     defined   -> round-robin arbitration with a one-bit priority pointer
//     undefined -> fixed priority, requester 0 wins whenever it requests
//
//   Sequence per transaction: IDLE (grant + operand latch) -> CMP (compare)
//   -> DONE (done/res presented until req drops) -> IDLE.
module cmp_share_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             done0,
  output logic             res0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done1,
  output logic             res1,
  output logic             busy,
  output logic             gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_gnt_id;
  logic             r_done0;
  logic             r_done1;
  logic             r_res0;
  logic             r_res1;

  logic             w_any_req;
  logic             w_winner;
  logic             w_req_gnt;
  logic             w_cmp;
  logic             w_grant;
  logic             w_release;

`ifdef CMP_ARB_RR_EN
  // Priority pointer: names the requester that wins a tie next time.
  logic             r_ptr;

  // Round-robin pick: the pointer breaks ties, a lone requester always wins.
  always_comb begin
    w_winner = 1'b0;
    if (req0 && req1) begin
      w_winner = r_ptr;
    end else begin
      w_winner = req1;
    end
  end

  // After every grant the pointer moves to the requester that did not win.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_grant) begin
      r_ptr <= ~w_winner;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    w_winner = 1'b0;
    if (!req0 && req1) begin
      w_winner = 1'b1;
    end
  end
`endif

  // Request decode and the shared comparator itself.
  always_comb begin
    w_any_req = req0 | req1;
    w_req_gnt = r_gnt_id ? req1 : req0;
    w_cmp     = |(r_op_a ^ r_op_b);
  end

  // Next-state logic; grant and release strobes are derived here as well.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // A requester that drops req early still gets its one-cycle done.
        if (!w_req_gnt) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch and grant index; operands are frozen from the grant edge on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_gnt_id <= 1'b0;
    end else if (w_grant) begin
      r_op_a   <= w_winner ? a1 : a0;
      r_op_b   <= w_winner ? b1 : b0;
      r_gnt_id <= w_winner;
    end else if (w_release) begin
      r_gnt_id <= 1'b0;
    end
  end

  // Completion and result registers; res of a side changes only on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_res0  <= 1'b0;
      r_res1  <= 1'b0;
    end else if (r_state == S_CMP) begin
      if (r_gnt_id) begin
        r_done1 <= 1'b1;
        r_res1  <= w_cmp;
      end else begin
        r_done0 <= 1'b1;
        r_res0  <= w_cmp;
      end
    end else if (w_release) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end
  end

  // Output drive.
  always_comb begin
    done0  = r_done0;
    done1  = r_done1;
    res0   = r_res0;
    res1   = r_res1;
    busy   = (r_state != S_IDLE);
    gnt_id = r_gnt_id;
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed transactions, an expected queue of
// {grant id, result} filled when a request is issued, and a monitor that
// pops and compares on each rising done.
module tb_cmp_share_arbiter;

  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic         req0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         done0;
  logic         res0;
  logic         req1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         done1;
  logic         res1;
  logic         busy;
  logic         gnt_id;

  int total;
  int bad;

  logic [1:0] exp_q[$];
  logic       prev_done0;
  logic       prev_done1;
  logic       done1_seen;

  cmp_share_arbiter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .done0  (done0),
    .res0   (res0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .done1  (done1),
    .res1   (res1),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #2;
    if (done1) done1_seen = 1'b1;
    if ((done0 && !prev_done0) || (done1 && !prev_done1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {done1, done0}, 2'b00);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("done_line", {30'd0, done1, done0}, e[1] ? 32'd2 : 32'd1);
        check("gnt_res", {30'd0, gnt_id, (done1 ? res1 : res0)}, {30'd0, e});
      end
    end
    prev_done0 = done0;
    prev_done1 = done1;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic exp_res);
    exp_q.push_back({id, exp_res});
    if (id) begin
      a1 = a; b1 = b; req1 = 1'b1;
    end else begin
      a0 = a; b0 = b; req0 = 1'b1;
    end
  endtask

  task automatic wait_done(input logic id);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = id ? done1 : done0;
    end
    check(id ? "wait_done1" : "wait_done0", seen, 1'b1);
  endtask

  task automatic release_req(input logic id);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    check("done_low_after_release", {done1, done0}, 2'b00);
    check("busy_low_after_release", busy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic order_id;
    logic [3:0] exp_order;
    logic [3:0] exp_res_vec;
    total = 0; bad = 0;
    prev_done0 = 1'b0; prev_done1 = 1'b0; done1_seen = 1'b0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_done", {done1, done0}, 2'b00);
    check("rst_res", {res1, res0}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", gnt_id, 1'b0);

    // T1: equal operands on requester 0, cycle-accurate latency
    issue(1'b0, 6'b110110, 6'b110110, 1'b0);
    @(negedge clk);                        // grant edge passed, now in CMP
    check("t1_busy_cmp", busy, 1'b1);
    check("t1_done_not_yet", done0, 1'b0);
    check("t1_gnt_cmp", gnt_id, 1'b0);
    @(negedge clk);                        // second edge passed, now in DONE
    check("t1_done0", done0, 1'b1);
    check("t1_res0", res0, 1'b0);
    check("t1_done1_quiet", done1, 1'b0);
    release_req(1'b0);

    // T2: unequal operands on requester 0
    issue(1'b0, 6'b110110, 6'b101010, 1'b1);
    wait_done(1'b0);
    check("t2_res0", res0, 1'b1);
    release_req(1'b0);

    // T3: requester 1 alone, all-ones vs all-zeros, res0 must hold
    issue(1'b1, 6'b111111, 6'b000000, 1'b1);
    wait_done(1'b1);
    check("t3_gnt1", gnt_id, 1'b1);
    check("t3_res1", res1, 1'b1);
    check("t3_res0_hold", res0, 1'b1);
    check("t3_done0_quiet", done0, 1'b0);
    release_req(1'b1);

    // T4: both requesting after reset, immediate re-requests, 4 grants
    do_reset();
    done1_seen = 1'b0;
`ifdef CMP_ARB_RR_EN
    exp_order   = 4'b1010;                 // bit i = grant id of transaction i
    exp_res_vec = 4'b1010;
`else
    exp_order   = 4'b0000;
    exp_res_vec = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back({exp_order[i], exp_res_vec[i]});
    a0 = 6'b000001; b0 = 6'b000001;        // equal   -> 0
    a1 = 6'b010101; b1 = 6'b010100;        // differ  -> 1
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge clk);
        seen = done0 | done1;
      end
      check("t4_done_wait", seen, 1'b1);
      order_id = done1;
      check("t4_grant_order", order_id, exp_order[i]);
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
      end else begin
        if (order_id) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        if (order_id) req1 = 1'b1; else req0 = 1'b1;
      end
    end
    @(negedge clk);
    check("t4_idle", busy, 1'b0);
`ifndef CMP_ARB_RR_EN
    check("t4_no_done1", done1_seen, 1'b0);
`endif

    // T5: operand change during CMP does not affect the result
    issue(1'b0, 6'b001100, 6'b001100, 1'b0);
    @(negedge clk);                        // in CMP
    a0 = 6'b111000;
    wait_done(1'b0);
    check("t5_res0_latched", res0, 1'b0);
    release_req(1'b0);

    // T6: reset during CMP with req1 held; aborted job must not complete
    issue(1'b1, 6'b101010, 6'b101011, 1'b1);
    @(negedge clk);                        // in CMP
    check("t6_busy_cmp", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy_after_rst", busy, 1'b0);
    check("t6_done1_after_rst", done1, 1'b0);
    check("t6_gnt_after_rst", gnt_id, 1'b0);
    wait_done(1'b1);
    check("t6_res1", res1, 1'b1);
    release_req(1'b1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #50000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
